burst_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares the single burst-master stream (valid/ready/data/last) between NUM_REQ requesters.
- Grant is held for a whole burst: from the arbitration decision until the handshake on the beat carrying last.
- Sits between the APB-side burst producers and the burst-master port; the per-burst beat count is exported for the scoreboard and debug.

---
 rtl/burst_sched_pkg.sv | 23 ++
 rtl/burst_rr_scheduler_rr_pick.sv | 32 +++
 rtl/burst_rr_scheduler.sv | 124 ++++++++++++
 tb/tb_burst_rr_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_sched_pkg.sv
// Shared types, widths and helpers for the burst round-robin scheduler.
package burst_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  localparam int unsigned BEAT_CNT_W  = 8;
  localparam int unsigned RR_PTR_W    = 3;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 8;

  // Round-robin pointer advance with wrap at n requesters.
  function automatic logic [RR_PTR_W-1:0] next_rr(input logic [RR_PTR_W-1:0] ptr,
                                                  input int unsigned          n);
    int unsigned nxt;
    nxt = 32'(ptr) + 32'd1;
    if (nxt >= n) nxt = 0;
    return RR_PTR_W'(nxt);
  endfunction

endpackage

// File: rtl/burst_rr_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i,
// wrapping around, returned as a one-hot vector.
module rr_pick
  import burst_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [RR_PTR_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic                any_o
);

  logic found;

  // Scan offsets 0..NUM_REQ-1 from the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == ((32'(ptr_i) + k) % NUM_REQ)) && req_i[i]) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/burst_rr_scheduler.sv
// Round-robin burst scheduler: one requester owns the shared burst stream
// from arbitration until the handshake of its last beat.
// Optional burst-length enforcement: define BURST_SCHED_LEN_CHECK_EN.
module burst_rr_scheduler
  import burst_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      burst_valid,
  output logic [DATA_W-1:0]         burst_data,
  output logic                      burst_last,
  input  logic                      burst_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [BEAT_CNT_W-1:0]     beat_cnt,
  output logic                      len_err
);

`ifdef BURST_SCHED_LEN_CHECK_EN
  localparam bit LEN_CHECK_EN = 1'b1;
`else
  localparam bit LEN_CHECK_EN = 1'b0;
`endif
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT_IDX = BEAT_CNT_W'(MAX_LEN - 1);

  sched_state_e            state_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [RR_PTR_W-1:0]     rr_ptr_q;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q;
  logic                    len_err_q;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic                    pick_any;
  logic                    owner_valid;
  logic                    owner_last;
  logic [DATA_W-1:0]       owner_data;
  logic [RR_PTR_W-1:0]     owner_idx;
  logic                    len_hit;
  logic                    hs;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  // Owner selection by AND-OR masking so non-owner X never leaks through.
  always_comb begin
    owner_data = '0;
    owner_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_data = owner_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
      if (grant_q[i]) owner_idx = RR_PTR_W'(i);
    end
    owner_valid = |(req_valid & grant_q);
    owner_last  = |(req_last & grant_q);
    len_hit     = LEN_CHECK_EN && (beat_cnt_q == LAST_BEAT_IDX);
  end

  // Stream pass-through while a burst is owned; quiet otherwise.
  always_comb begin
    burst_valid = 1'b0;
    burst_data  = '0;
    burst_last  = 1'b0;
    req_ready   = '0;
    if (state_q == BURST) begin
      burst_valid = owner_valid;
      burst_data  = owner_valid ? owner_data : '0;
      burst_last  = owner_last | (len_hit & owner_valid);
      req_ready   = grant_q & {NUM_REQ{burst_ready}};
    end
  end

  assign hs = burst_valid & burst_ready;

  // Arbitration / burst ownership FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_gnt;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (hs) begin
            if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 1'b1;
            if (burst_last) begin
              state_q   <= IDLE;
              grant_q   <= '0;
              rr_ptr_q  <= next_rr(owner_idx, NUM_REQ);
              len_err_q <= len_hit & ~owner_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == BURST);
  assign beat_cnt = beat_cnt_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Directed self-checking bench for burst_rr_scheduler (NUM_REQ=4, DATA_W=8).
module tb_burst_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        burst_valid;
  logic [7:0]  burst_data;
  logic        burst_last;
  logic        burst_ready;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  beat_cnt;
  logic        len_err;

  int checks = 0;
  int errors = 0;

  burst_rr_scheduler #(.NUM_REQ(4), .DATA_W(8), .MAX_LEN(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .burst_valid (burst_valid),
    .burst_data  (burst_data),
    .burst_last  (burst_last),
    .burst_ready (burst_ready),
    .grant       (grant),
    .busy        (busy),
    .beat_cnt    (beat_cnt),
    .len_err     (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int r, input logic [7:0] v);
    req_data[r*8 +: 8] = v;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; burst_ready = 1'b1;
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_beat", 32'(beat_cnt), 32'h0);
    chk("rst_lenerr", 32'(len_err), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_bvalid", 32'(burst_valid), 32'h0);
    chk("rst_bdata", 32'(burst_data), 32'h0);
    chk("rst_blast", 32'(burst_last), 32'h0);
    cyc(); cyc();
    rst = 1'b0;

    // Requester 1: three beats 0x11..0x13
    cyc();
    req_valid = 4'b0010; set_d(1, 8'h11);
    #1;
    chk("t1_idle_grant", 32'(grant), 32'h0);
    chk("t1_idle_valid", 32'(burst_valid), 32'h0);
    cyc();
    #1;
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_b1", 32'(burst_data), 32'h11);
    chk("t1_rdy", 32'(req_ready), 32'h2);
    chk("t1_cnt0", 32'(beat_cnt), 32'h0);
    cyc();
    set_d(1, 8'h12);
    #1;
    chk("t1_b2", 32'(burst_data), 32'h12);
    chk("t1_cnt1", 32'(beat_cnt), 32'h1);
    cyc();
    set_d(1, 8'h13); req_last = 4'b0010;
    #1;
    chk("t1_b3", 32'(burst_data), 32'h13);
    chk("t1_last", 32'(burst_last), 32'h1);
    cyc();
    req_valid = '0; req_last = '0; set_d(1, 8'h00);
    #1;
    chk("t1_end_grant", 32'(grant), 32'h0);
    chk("t1_end_cnt", 32'(beat_cnt), 32'h3);
    chk("t1_end_busy", 32'(busy), 32'h0);

    // Reset to rr_ptr=0, then requesters 0,2,3 compete with 2-beat bursts
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 4'b1101; set_d(0, 8'h01); set_d(2, 8'h21); set_d(3, 8'h31);
    #1;
    chk("t2_idle", 32'(grant), 32'h0);
    cyc();
    #1;
    chk("t2_g0", 32'(grant), 32'h1);
    chk("t2_d01", 32'(burst_data), 32'h01);
    cyc();
    set_d(0, 8'h02); req_last = 4'b0001;
    #1;
    chk("t2_d02", 32'(burst_data), 32'h02);
    chk("t2_l0", 32'(burst_last), 32'h1);
    cyc();
    req_valid = 4'b1100; req_last = '0;
    #1;
    chk("t2_gap1", 32'(grant), 32'h0);
    chk("t2_gap1_v", 32'(burst_valid), 32'h0);
    cyc();
    #1;
    chk("t2_g2", 32'(grant), 32'h4);
    chk("t2_d21", 32'(burst_data), 32'h21);
    cyc();
    set_d(2, 8'h22); req_last = 4'b0100;
    #1;
    chk("t2_d22", 32'(burst_data), 32'h22);
    cyc();
    req_valid = 4'b1000; req_last = '0;
    #1;
    chk("t2_gap2", 32'(grant), 32'h0);
    cyc();
    #1;
    chk("t2_g3", 32'(grant), 32'h8);
    chk("t2_d31", 32'(burst_data), 32'h31);
    cyc();
    set_d(3, 8'h32); req_last = 4'b1000;
    #1;
    chk("t2_d32", 32'(burst_data), 32'h32);
    cyc();
    req_valid = '0; req_last = '0; req_data = '0;
    #1;
    chk("t2_end_grant", 32'(grant), 32'h0);
    chk("t2_end_cnt", 32'(beat_cnt), 32'h2);

    // Owner 2 with burst_ready toggling; requester 0 waits (rr_ptr=0)
    req_valid = 4'b0100; set_d(2, 8'h41);
    cyc();
    req_valid = 4'b0101; set_d(0, 8'hA0);
    #1;
    chk("t3_g2", 32'(grant), 32'h4);
    chk("t3_rdy1", 32'(req_ready), 32'h4);
    chk("t3_d41", 32'(burst_data), 32'h41);
    cyc();
    set_d(2, 8'h42); burst_ready = 1'b0;
    #1;
    chk("t3_rdy0", 32'(req_ready), 32'h0);
    chk("t3_cnt1", 32'(beat_cnt), 32'h1);
    cyc();
    burst_ready = 1'b1;
    #1;
    chk("t3_hold_d", 32'(burst_data), 32'h42);
    chk("t3_hold_cnt", 32'(beat_cnt), 32'h1);
    chk("t3_hold_g", 32'(grant), 32'h4);
    chk("t3_rdy2", 32'(req_ready), 32'h4);
    cyc();
    set_d(2, 8'h43); req_last = 4'b0100; burst_ready = 1'b0;
    #1;
    chk("t3_cnt2", 32'(beat_cnt), 32'h2);
    chk("t3_nopreempt", 32'(grant), 32'h4);
    cyc();
    burst_ready = 1'b1;
    #1;
    chk("t3_hold2_cnt", 32'(beat_cnt), 32'h2);
    cyc();
    req_valid = 4'b0001; req_last = '0; set_d(2, 8'h00);
    #1;
    chk("t3_end_grant", 32'(grant), 32'h0);
    chk("t3_end_cnt", 32'(beat_cnt), 32'h3);
    cyc();
    req_last = 4'b0001;
    #1;
    chk("t3_g0", 32'(grant), 32'h1);
    chk("t3_d_a0", 32'(burst_data), 32'hA0);
    cyc();
    req_valid = '0; req_last = '0; req_data = '0;
    #1;
    chk("t3_g0_done", 32'(grant), 32'h0);

    // Reset during beat 2 of a 4-beat burst from requester 1 (rr_ptr=1)
    req_valid = 4'b0010; set_d(1, 8'h51);
    cyc();
    #1;
    chk("t4_g1", 32'(grant), 32'h2);
    cyc();
    set_d(1, 8'h52);
    #1;
    chk("t4_b2_v", 32'(burst_valid), 32'h1);
    chk("t4_b2_d", 32'(burst_data), 32'h52);
    rst = 1'b1;
    #1;
    chk("t4_rst_grant", 32'(grant), 32'h0);
    chk("t4_rst_valid", 32'(burst_valid), 32'h0);
    chk("t4_rst_data", 32'(burst_data), 32'h0);
    chk("t4_rst_ready", 32'(req_ready), 32'h0);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    chk("t4_rst_cnt", 32'(beat_cnt), 32'h0);
    cyc();
    rst = 1'b0;
    req_valid = 4'b1001; req_last = 4'b1001; req_data = '0;
    set_d(0, 8'h61); set_d(3, 8'h71);
    #1;
    chk("t4_idle", 32'(busy), 32'h0);
    cyc();
    #1;
    chk("t4_ptr0_pick", 32'(grant), 32'h1);
    chk("t4_d61", 32'(burst_data), 32'h61);
    chk("t4_l61", 32'(burst_last), 32'h1);

    // Single-beat bursts, requester 3 twice
    cyc();
    req_valid = 4'b1000;
    #1;
    chk("t5_gap0", 32'(grant), 32'h0);
    chk("t5_cnt_r0", 32'(beat_cnt), 32'h1);
    cyc();
    #1;
    chk("t5_g3a", 32'(grant), 32'h8);
    chk("t5_d71", 32'(burst_data), 32'h71);
    cyc();
    #1;
    chk("t5_gap", 32'(grant), 32'h0);
    chk("t5_gap_v", 32'(burst_valid), 32'h0);
    chk("t5_cnt_a", 32'(beat_cnt), 32'h1);
    cyc();
    req_valid[1] = 1'bx; req_data[15:8] = 8'hxx;
    #1;
    chk("t5_g3b", 32'(grant), 32'h8);
    chk("t5_cnt_b0", 32'(beat_cnt), 32'h0);
    chk("t5_x_valid", 32'(burst_valid), 32'h1);
    chk("t5_x_data", 32'(burst_data), 32'h71);
    chk("t5_x_ready", 32'(req_ready), 32'h8);
    cyc();
    req_valid = '0; req_last = '0; req_data = '0;
    #1;
    chk("t5_end_grant", 32'(grant), 32'h0);
    chk("t5_cnt_b", 32'(beat_cnt), 32'h1);
    chk("t5_lenerr", 32'(len_err), 32'h0);

`ifdef BURST_SCHED_LEN_CHECK_EN
    // Requester 0 streams 20 beats with no last; forced split at 16
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 4'b0001; set_d(0, 8'd1);
    cyc();
    for (int b = 1; b <= 16; b++) begin
      set_d(0, 8'(b));
      #1;
      chk("t6_last", 32'(burst_last), (b == 16) ? 32'h1 : 32'h0);
      chk("t6_lenerr_in", 32'(len_err), 32'h0);
      cyc();
    end
    set_d(0, 8'd17);
    #1;
    chk("t6_lenerr", 32'(len_err), 32'h1);
    chk("t6_release", 32'(grant), 32'h0);
    cyc();
    #1;
    chk("t6_lenerr_pulse", 32'(len_err), 32'h0);
    chk("t6_regrant", 32'(grant), 32'h1);
    for (int b = 17; b <= 20; b++) begin
      set_d(0, 8'(b));
      #1;
      chk("t6_tail_d", 32'(burst_data), 32'(b));
      chk("t6_tail_last", 32'(burst_last), 32'h0);
      cyc();
    end
    req_valid = '0;
    #1;
    chk("t6_tail_cnt", 32'(beat_cnt), 32'h4);
    rst = 1'b1; cyc(); rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
